mul_add_pipe: RTL and testbench
===============================

# mul_add_pipe

Pipelined unsigned multiply-add that computes product = a × b + c at one result per enabled cycle. It is the inverse companion to the team's pipelined divider: it takes a 12-bit quotient, a 13-bit divisor and a 13-bit remainder, and reconstructs the dividend. The datapath is also usable as a general 12×13 MAC. It sits in the same arithmetic datapath, and the checker path feeds it straight from divider outputs.

## Interface
Parameters: none. Widths are fixed by the shared package.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high; clock is clk.
- en  input  1  global pipeline advance; when 0, every stage register, including outputs, holds.
- in_valid  input  1  a/b/c carry an operation this cycle; sampled only when en=1.
- a  input  12  multiplicand (quotient side), unsigned.
- b  input  13  multiplier (divisor side), unsigned.
- c  input  13  addend (remainder side), unsigned.
- out_valid  output  1  product carries a result; registered.
- product  output  25  a*b+c, unsigned, registered.

## Operation
- Stage 0 (input register): on an edge with en=1, captures a, b, c and v0=in_valid. The register loads even when in_valid=0, so bubbles travel as v=0.
- Stages 1..12 each consume one bit of a, MSB first, using the Horner form.
  - Stage k computes acc_k = (acc_{k-1} << 1) + (a[12-k] ? b : 0), with acc_0 = 0.
  - b, c and the valid bit are carried alongside.
  - acc is 25 bits wide, so there is no overflow: acc_12 = a*b ≤ 33,542,145.
- Stage 13 (output register): product = acc_12 + c and out_valid = v12. The worst case is 4095·8191 + 8191 = 33,550,336 < 2^25, so the result is always exact and never truncated.
- Bubble handling: results with v=0 still propagate through the datapath. product is don't-care when out_valid=0, but the bench may check that it is 0 only after reset.
- Ordering: results emerge in acceptance order. There is no reordering or dropping while en=1.

## Timing
- Latency: inputs sampled at enabled edge N appear on product/out_valid after enabled edge N+13. This is exactly 13 enabled edges later; disabled edges are not counted.
- Throughput: 1 operation per enabled cycle. There is no backpressure output; the upstream stalls using en.
- en=0: all 14 register stages (including v0..v12, out_valid and product) hold their values. out_valid stays asserted if it was asserted, so the consumer must qualify it with en.
- Reset: on any edge with rst=1, every valid bit v0..v12 and out_valid go to 0, and product and all acc/operand registers go to 0. Reset takes priority over en.
- Reset mid-operation: every in-flight operation is discarded, with no partial output. From the edge after rst is released, the first possible out_valid comes 13 enabled edges after the next accepted input.
- Simultaneous rst=1, en=1, in_valid=1: the input is not captured.

## Structure
- Shared package holds the width constants:
  - A_W=12
  - B_W=13
  - C_W=13
  - P_W=25
  - N_STAGES=12 (bit stages)
  - LAT=13
- Sub-module mul_add_stage implements one Horner step.
  - Inputs: acc_in, a_in, b_in, c_in, v_in; the bit index is a parameter.
  - Registered outputs: acc_out, a_out, b_out, c_out, v_out, with shared clk/rst/en.
- The top level instantiates 12 mul_add_stage instances with a generate loop, and adds the input and output registers.

## Test plan
- Reset: hold rst for 3 cycles with en=1 and in_valid=1 → out_valid=0 and product=0 during reset, and no out_valid for 13 enabled edges after release.
- Corner values:
  - a=0, b=8191, c=0 → 0.
  - a=4095, b=8191, c=8191 → 33,550,336 (0x1FFF000), exactly 13 edges after acceptance.
  - a=1234, b=5, c=0 → 6170.
- Divider round trip: (q=14, d=7, r=2) → 100; (q=4095, d=1, r=0) → 4095; (q=0, d=8191, r=8190) → 8190.
- Streaming:
  - 200 back-to-back random triples with en=1 → one out_valid per cycle, in order, each equal to a*b+c, with the first one 13 edges after the first input.
  - Random in_valid bubbles → the valid pattern is reproduced 13 edges later.
- Stall: drop en for 5 cycles mid-stream with 6 operations in flight → outputs frozen throughout, all 6 results correct, and latency for each equal to 13 + 5 cycles of wall time.
- Reset in flight: assert rst for 1 cycle with 10 operations in flight → out_valid=0 on the next edge, none of the 10 ever appear, and an input accepted after release emerges exactly 13 enabled edges later.

Source files
------------

// File: rtl/mul_add_pipe_pkg.sv
// Shared widths and operand types for the multiply-add pipeline.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mul_add_pipe_pkg;

    localparam int A_W      = 12;  // quotient / multiplicand
    localparam int B_W      = 13;  // divisor / multiplier
    localparam int C_W      = 13;  // remainder / addend
    localparam int P_W      = 25;  // product, wide enough for 4095*8191+8191
    localparam int N_STAGES = 12;  // one Horner stage per bit of a
    localparam int LAT      = 13;  // enabled edges from input capture to output

    typedef logic [A_W-1:0] a_t;
    typedef logic [B_W-1:0] b_t;
    typedef logic [C_W-1:0] c_t;
    typedef logic [P_W-1:0] p_t;

endpackage

// File: rtl/mul_add_pipe_if.sv
// Operand/result bundle between the divider-side producer and the multiply-add pipe.
// Latency: n/a (wires only).
// Backpressure: none; the producer stalls the pipe through en.
interface mul_add_pipe_if;
    import mul_add_pipe_pkg::*;

    logic en;
    logic in_valid;
    a_t   a;
    b_t   b;
    c_t   c;
    logic out_valid;
    p_t   product;

    modport master (output en, output in_valid, output a, output b, output c,
                    input  out_valid, input product);
    modport slave  (input  en, input  in_valid, input  a, input  b, input  c,
                    output out_valid, output product);
endinterface

// File: rtl/mul_add_pipe_stage.sv
// One Horner step: acc_out = (acc_in << 1) + (a_in[BIT] ? b_in : 0), operands carried along.
// Latency: 1 enabled edge.
// Backpressure: none; holds every register while en=0.
module mul_add_stage
    import mul_add_pipe_pkg::*;
#(
    parameter int BIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  p_t   acc_in,
    input  a_t   a_in,
    input  b_t   b_in,
    input  c_t   c_in,
    input  logic v_in,
    output p_t   acc_out,
    output a_t   a_out,
    output b_t   b_out,
    output c_t   c_out,
    output logic v_out
);

    p_t w_addend;
    p_t w_acc_next;

    // The running sum never exceeds a*b < 2^25, so dropping acc_in's MSB on the shift is lossless.
    assign w_addend   = a_in[BIT] ? P_W'(b_in) : '0;
    assign w_acc_next = {acc_in[P_W-2:0], 1'b0} + w_addend;

    // Stage register: reset clears everything, otherwise load only on enabled edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out <= '0;
            a_out   <= '0;
            b_out   <= '0;
            c_out   <= '0;
            v_out   <= 1'b0;
        end else if (en) begin
            acc_out <= w_acc_next;
            a_out   <= a_in;
            b_out   <= b_in;
            c_out   <= c_in;
            v_out   <= v_in;
        end
    end

endmodule

// File: rtl/mul_add_pipe.sv
// Pipelined unsigned product = a*b + c; rebuilds the dividend from quotient/divisor/remainder.
// Latency: 13 enabled edges from input capture to product/out_valid; 1 result per enabled cycle.
// Backpressure: none; en=0 freezes every stage including the outputs.
module mul_add_pipe
    import mul_add_pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul_add_pipe_if.slave  io_bus
);

    // Input register (stage 0). Loads bubbles too so the valid pattern is preserved.
    a_t   r_a;
    b_t   r_b;
    c_t   r_c;
    logic r_v;

    // Output register (stage 13).
    p_t   r_product;
    logic r_out_valid;

    // Inter-stage links; index k is the output of Horner stage k, index 0 seeds stage 1.
    p_t   w_acc [0:N_STAGES];
    a_t   w_a   [0:N_STAGES];
    b_t   w_b   [0:N_STAGES];
    c_t   w_c   [0:N_STAGES];
    logic w_v   [0:N_STAGES];

    // The last stage's copies of a and b have no consumer past the final addition.
    logic w_unused;

    // Capture operands on every enabled edge; reset wins over en so a reset-cycle input is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_v <= 1'b0;
        end else if (io_bus.en) begin
            r_a <= io_bus.a;
            r_b <= io_bus.b;
            r_c <= io_bus.c;
            r_v <= io_bus.in_valid;
        end
    end

    assign w_acc[0] = '0;
    assign w_a[0]   = r_a;
    assign w_b[0]   = r_b;
    assign w_c[0]   = r_c;
    assign w_v[0]   = r_v;

    // Stage k consumes bit A_W-k of a, MSB first.
    for (genvar k = 1; k <= N_STAGES; k++) begin : g_stage
        mul_add_stage #(
            .BIT (A_W - k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (io_bus.en),
            .acc_in  (w_acc[k-1]),
            .a_in    (w_a[k-1]),
            .b_in    (w_b[k-1]),
            .c_in    (w_c[k-1]),
            .v_in    (w_v[k-1]),
            .acc_out (w_acc[k]),
            .a_out   (w_a[k]),
            .b_out   (w_b[k]),
            .c_out   (w_c[k]),
            .v_out   (w_v[k])
        );
    end

    assign w_unused = ^{w_a[N_STAGES], w_b[N_STAGES]};

    // Final addend; the maximum 4095*8191+8191 still fits P_W bits exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else if (io_bus.en) begin
            r_product   <= w_acc[N_STAGES] + P_W'(w_c[N_STAGES]);
            r_out_valid <= w_v[N_STAGES];
        end
    end

    assign io_bus.product   = r_product;
    assign io_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mul_add_pipe.sv
// Self-checking bench for mul_add_pipe: directed corners, divider round trips, streams, stalls, resets.
// Latency: every expected result carries the enabled-edge count at which it must appear.
// Backpressure: stalls are applied through en only.
module tb_mul_add_pipe;
    import mul_add_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mul_add_pipe_if bus ();

    mul_add_pipe dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp;  // expected product
        int tgt;  // enabled-edge count at which it must appear
    } sb_t;

    sb_t sbq[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  = 0;   // enabled, non-reset edges seen so far
    int   cyc     = 0;   // all rising edges seen so far
    logic en_edge = 1'b0; // last edge advanced the pipe

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edge bookkeeping used to time-stamp acceptances and qualify outputs.
    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.en) en_cnt++;
        en_edge <= bus.en && !rst;
    end

    // Output monitor: every fresh out_valid must match the oldest pending expectation, on time.
    always @(negedge clk) begin
        if (en_edge && bus.out_valid === 1'b1) begin
            check("result_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                sb_t e;
                e = sbq.pop_front();
                check("product", 32'(bus.product), e.exp);
                check("latency_edges", en_cnt, e.tgt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation for the next edge; en must be 1 so it is accepted there.
    task automatic send(input int av, input int bv, input int cv, input int exp);
        bus.in_valid = 1'b1;
        bus.a = a_t'(av);
        bus.b = b_t'(bv);
        bus.c = c_t'(cv);
        sbq.push_back('{exp, en_cnt + 1 + LAT});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        int av, bv, cv;
        av = int'($urandom_range(0, 4095));
        bv = int'($urandom_range(0, 8191));
        cv = int'($urandom_range(0, 8191));
        send(av, bv, cv, av * bv + cv);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed cyc=%0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic       ov0;
        p_t         p0;
        int         start;
        logic [0:0] got;
        int         lat;

        // Reset held with a live input: nothing may be captured or emitted.
        rst = 1'b1;
        bus.en = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = '1;
        bus.b = '1;
        bus.c = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_out_valid", 32'(bus.out_valid), 32'd0);
            check("reset_product", 32'(bus.product), 32'd0);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        idle(16);

        // Corner values and divider round trips.
        send(0, 8191, 0, 0);
        send(4095, 8191, 8191, 33550336);
        send(1234, 5, 0, 6170);
        send(14, 7, 2, 100);
        send(4095, 1, 0, 4095);
        send(0, 8191, 8190, 8190);
        idle(16);

        // 200 back-to-back random operations, with a 5-cycle stall while results are flowing.
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                bus.en = 1'b0;
                ov0 = bus.out_valid;
                p0  = bus.product;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check("stream_stall_valid_frozen", 32'(bus.out_valid), 32'(ov0));
                    check("stream_stall_product_frozen", 32'(bus.product), 32'(p0));
                end
                bus.en = 1'b1;
            end
            send_rand();
        end
        idle(16);

        // Random bubbles: the valid pattern must reappear 13 enabled edges later.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                send_rand();
            end else begin
                bus.in_valid = 1'b0;
                bus.a = a_t'($urandom_range(0, 4095));
                bus.b = b_t'($urandom_range(0, 8191));
                bus.c = c_t'($urandom_range(0, 8191));
                step();
            end
        end
        idle(16);

        // Six operations in flight, then en low for 5 cycles: wall latency becomes 13 + 5.
        start = cyc + 1;
        for (int i = 0; i < 6; i++) send_rand();
        bus.en = 1'b0;
        ov0 = bus.out_valid;
        p0  = bus.product;
        for (int s = 0; s < 5; s++) begin
            step();
            check("stall6_valid_frozen", 32'(bus.out_valid), 32'(ov0));
            check("stall6_product_frozen", 32'(bus.product), 32'(p0));
        end
        bus.en = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (en_edge && bus.out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("stall6_output_seen", 32'(got), 32'd1);
        lat = cyc - start;
        check("stall6_wall_latency", lat, 18);
        step();
        idle(16);

        // Reset with 10 operations in flight: all are discarded.
        for (int i = 0; i < 10; i++) send_rand();
        rst = 1'b1;
        sbq.delete();
        step();
        check("rst_flight_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flight_product", 32'(bus.product), 32'd0);
        rst = 1'b0;
        idle(20);
        send(100, 200, 300, 20300);
        idle(16);

        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
